codebook_vram_sched: RTL and testbench

Schedules the PVR texture unit's single VRAM read port between the VQ codebook cache fill engine and the texel fetch path. It turns the cache's word-by-word fill request (`cb_wait` / `cb_offset`) into aligned VRAM bursts and forwards each returned beat to the cache as `cb_valid`. Between bursts it interleaves single-beat texel reads under round-robin arbitration. It sits between `codebook_cache` / texel address generation and the VRAM (SDRAM/DDR) read master.

---
 rtl/pvr_vram_pkg.sv | 27 ++
 rtl/codebook_vram_sched.sv | 133 +++++++++++++
 tb/tb_codebook_vram_sched.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pvr_vram_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pvr_vram_pkg                                                  |
// | Brief    : Shared types and constants for the PVR texture-unit VRAM      |
// |            read-port scheduler.                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package pvr_vram_pkg;

  // Scheduler states: codebook burst request/data, texel request/data.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CB_REQ  = 3'd1,
    ST_CB_DATA = 3'd2,
    ST_TX_REQ  = 3'd3,
    ST_TX_DATA = 3'd4
  } vram_state_t;

  // Codebook size in 64-bit words.
  localparam int CB_WORDS        = 256;
  // Bytes per VRAM read beat.
  localparam int VRAM_BEAT_BYTES = 8;
  // Width of the VRAM burst-count field (holds up to CB_WORDS).
  localparam int BURSTCNT_W      = 9;

endpackage : pvr_vram_pkg
`default_nettype wire

// File: rtl/codebook_vram_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : codebook_vram_sched                                           |
// | Brief    : Shares the single VRAM read port between the VQ codebook      |
// |            cache fill (aligned bursts) and single-beat texel reads,      |
// |            with round-robin arbitration between the two.                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module codebook_vram_sched
  import pvr_vram_pkg::*;
#(
  parameter int ADDR_WIDTH = 23,
  parameter int BURST_LEN  = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  // codebook cache fill side
  input  logic                  cb_wait,
  input  logic [7:0]            cb_offset,
  input  logic [ADDR_WIDTH-1:0] cb_base,
  output logic                  cb_valid,
  output logic [63:0]           cb_data,
  // texel fetch side
  input  logic                  tex_req,
  input  logic [ADDR_WIDTH-1:0] tex_addr,
  output logic                  tex_ack,
  output logic                  tex_valid,
  output logic [63:0]           tex_data,
  // VRAM read master
  output logic                  vram_rd,
  output logic [ADDR_WIDTH-1:0] vram_addr,
  output logic [BURSTCNT_W-1:0] vram_burstcnt,
  input  logic                  vram_waitrequest,
  input  logic                  vram_rdvalid,
  input  logic [63:0]           vram_din
);

  localparam int BEAT_SHIFT = $clog2(VRAM_BEAT_BYTES);

  vram_state_t           r_state;
  logic                  r_last_cb;
  logic [BURSTCNT_W-1:0] r_beat_cnt;

  logic                  w_grant_cb;
  logic                  w_grant_tx;
  logic                  w_accept;
  logic                  w_last_beat;
  logic [ADDR_WIDTH-1:0] w_cb_addr;

  // Codebook word index scaled to a byte offset from the codebook base.
  assign w_cb_addr = cb_base + (ADDR_WIDTH'(cb_offset) << BEAT_SHIFT);

  // Round-robin: on contention, grant whichever side was not served last.
  assign w_grant_cb = cb_wait && (!tex_req || !r_last_cb);
  assign w_grant_tx = tex_req && (!cb_wait ||  r_last_cb);

  assign w_accept    = vram_rd && !vram_waitrequest;
  assign w_last_beat = vram_rdvalid && (r_beat_cnt == BURSTCNT_W'(BURST_LEN - 1));

  // Returned beats pass straight through; a fill cancelled mid-burst drains silently.
  assign cb_valid  = (r_state == ST_CB_DATA) && vram_rdvalid && cb_wait;
  assign cb_data   = cb_valid ? vram_din : 64'd0;
  assign tex_valid = (r_state == ST_TX_DATA) && vram_rdvalid;
  assign tex_data  = tex_valid ? vram_din : 64'd0;
  assign tex_ack   = (r_state == ST_TX_REQ) && w_accept;

  // Scheduler FSM with registered VRAM command outputs held stable under stall.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_last_cb     <= 1'b0;
      r_beat_cnt    <= '0;
      vram_rd       <= 1'b0;
      vram_addr     <= '0;
      vram_burstcnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_cb) begin
            vram_rd       <= 1'b1;
            vram_addr     <= w_cb_addr;
            vram_burstcnt <= BURSTCNT_W'(BURST_LEN);
            r_state       <= ST_CB_REQ;
          end else if (w_grant_tx) begin
            vram_rd       <= 1'b1;
            vram_addr     <= tex_addr;
            vram_burstcnt <= BURSTCNT_W'(1);
            r_state       <= ST_TX_REQ;
          end
        end

        ST_CB_REQ: begin
          if (w_accept) begin
            vram_rd    <= 1'b0;
            r_last_cb  <= 1'b1;
            r_beat_cnt <= '0;
            r_state    <= ST_CB_DATA;
          end
        end

        ST_CB_DATA: begin
          if (w_last_beat) begin
            r_beat_cnt <= '0;
            r_state    <= ST_IDLE;
          end else if (vram_rdvalid) begin
            r_beat_cnt <= r_beat_cnt + BURSTCNT_W'(1);
          end
        end

        ST_TX_REQ: begin
          if (w_accept) begin
            vram_rd   <= 1'b0;
            r_last_cb <= 1'b0;
            r_state   <= ST_TX_DATA;
          end
        end

        ST_TX_DATA: begin
          if (vram_rdvalid) begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          vram_rd <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : codebook_vram_sched
`default_nettype wire

// File: tb/tb_codebook_vram_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_codebook_vram_sched                                        |
// | Brief    : Self-checking bench: behavioural codebook cache, texel        |
// |            requester and VRAM slave models around codebook_vram_sched.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_codebook_vram_sched;

  localparam int AW = 23;
  localparam int BL = 8;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          cb_wait;
  logic [7:0]    cb_offset;
  logic [AW-1:0] cb_base;
  logic          cb_valid;
  logic [63:0]   cb_data;
  logic          tex_req;
  logic [AW-1:0] tex_addr;
  logic          tex_ack;
  logic          tex_valid;
  logic [63:0]   tex_data;
  logic          vram_rd;
  logic [AW-1:0] vram_addr;
  logic [8:0]    vram_burstcnt;
  logic          vram_waitrequest;
  logic          vram_rdvalid;
  logic [63:0]   vram_din;

  always #5 clock = ~clock;

  codebook_vram_sched #(.ADDR_WIDTH(AW), .BURST_LEN(BL)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .cb_wait         (cb_wait),
    .cb_offset       (cb_offset),
    .cb_base         (cb_base),
    .cb_valid        (cb_valid),
    .cb_data         (cb_data),
    .tex_req         (tex_req),
    .tex_addr        (tex_addr),
    .tex_ack         (tex_ack),
    .tex_valid       (tex_valid),
    .tex_data        (tex_data),
    .vram_rd         (vram_rd),
    .vram_addr       (vram_addr),
    .vram_burstcnt   (vram_burstcnt),
    .vram_waitrequest(vram_waitrequest),
    .vram_rdvalid    (vram_rdvalid),
    .vram_din        (vram_din)
  );

  // Beat the VRAM model still owes, tagged with the requester that asked for it.
  typedef struct {
    logic [AW-1:0] addr;
    bit            is_cb;
    int            ready;
  } beat_t;

  beat_t beat_q[$];

  int checks = 0;
  int errors = 0;

  // Model state
  int            cyc = 0;
  bit            m_fill = 0;       // cache fill in progress
  int            m_words = 0;      // codebook words delivered to the cache
  int            drop_at = 0;      // cache abandons the fill after this many words
  logic [AW-1:0] m_base = '0;
  bit            t_pend = 0;
  bit            t_sat = 0;
  logic [AW-1:0] t_addr = '0;
  int            t_cbwait = 0;     // codebook bursts granted while a texel waited
  int            t_done = 0;
  bit            rand_wait = 0;
  bit            gaps = 0;
  int            lat_max = 1;
  int            force_wait = 0;
  bit            stray_en = 0;
  bit            alt_en = 0;
  int            last_type = 0;
  bit            idle_chk = 0;
  int            n_cb_cmds = 0;
  int            n_cb_pulses = 0;
  int            n_tx_acks = 0;
  int            n_rd_probe = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // VRAM contents: a fixed function of the byte address.
  function automatic logic [63:0] mem_word(input logic [AW-1:0] a);
    return {a, 9'h1B5, 32'(a) * 32'h9E37_79B1};
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = AW'($urandom);
    a[2:0] = 3'b000;
    return a;
  endfunction

  function automatic logic [AW-1:0] cb_word_addr(input int k);
    return m_base + AW'(k * 8);
  endfunction

  // One clock: drive inputs on the falling edge, then sample and score.
  task automatic step();
    int            kind;
    bit            acc;
    bit            both_pend;
    int            ty;
    int            lat;
    logic [AW-1:0] beat_addr;
    beat_t         b;
    kind = 0;
    beat_addr = '0;
    @(negedge clock);
    cyc++;
    cb_wait   = m_fill;
    cb_offset = m_words[7:0];
    cb_base   = m_base;
    if (t_sat && !t_pend) begin
      t_pend   = 1;
      t_addr   = rand_addr();
      t_cbwait = 0;
    end
    tex_req  = t_pend;
    tex_addr = t_addr;
    if (force_wait > 0 && vram_rd) begin
      vram_waitrequest = 1'b1;
      force_wait--;
    end else begin
      vram_waitrequest = rand_wait ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
    acc = vram_rd && !vram_waitrequest && reset_n;
    if (beat_q.size() != 0 && beat_q[0].ready <= cyc && (!gaps || $urandom_range(0, 3) != 0)) begin
      b = beat_q.pop_front();
      vram_rdvalid = 1'b1;
      vram_din     = mem_word(b.addr);
      kind         = b.is_cb ? 1 : 2;
      beat_addr    = b.addr;
    end else if (stray_en && beat_q.size() == 0) begin
      vram_rdvalid = 1'b1;
      vram_din     = {$urandom, $urandom};
    end else begin
      vram_rdvalid = 1'b0;
      vram_din     = {$urandom, $urandom};
    end
    #1;
    if (kind == 1) begin
      check("cb_valid_gate", cb_valid, m_fill);
      check("tex_valid_on_cb_beat", tex_valid, 0);
      if (m_fill && cb_valid) begin
        check("cb_data", cb_data, mem_word(cb_word_addr(m_words)));
        n_cb_pulses++;
        m_words++;
        if (m_words == 256 || m_words == drop_at) m_fill = 0;
      end
    end else if (kind == 2) begin
      check("tex_valid", tex_valid, 1);
      check("cb_valid_on_tx_beat", cb_valid, 0);
      check("tex_data", tex_data, mem_word(beat_addr));
      t_done++;
    end else begin
      check("no_valid", {cb_valid, tex_valid}, 0);
    end
    check("tex_ack", tex_ack, acc && (vram_burstcnt == 9'd1));
    if (idle_chk) check("idle_rd", vram_rd, 0);
    if (vram_rd && vram_addr == 23'h0ABC08 && vram_burstcnt == 9'd1) n_rd_probe++;
    if (acc) begin
      both_pend = t_pend && m_fill;
      lat = (lat_max <= 1) ? 1 : $urandom_range(1, lat_max);
      if (vram_burstcnt == 9'd1) begin
        ty = 2;
        check("tx_req_pending", t_pend, 1);
        check("tx_addr", vram_addr, t_addr);
        check("tx_wait_bound", (t_cbwait <= 1), 1);
        beat_q.push_back('{addr: vram_addr, is_cb: 1'b0, ready: cyc + lat});
        t_pend = 0;
        n_tx_acks++;
      end else begin
        ty = 1;
        check("cb_burstcnt", vram_burstcnt, BL);
        check("cb_req_pending", m_fill, 1);
        check("cb_addr", vram_addr, cb_word_addr(m_words));
        check("cb_align", m_words % BL, 0);
        for (int i = 0; i < int'(vram_burstcnt); i++)
          beat_q.push_back('{addr: vram_addr + AW'(i * 8), is_cb: 1'b1, ready: cyc + lat});
        n_cb_cmds++;
        if (t_pend) t_cbwait++;
      end
      if (alt_en && last_type != 0 && both_pend) check("alternate", (ty != last_type), 1);
      last_type = ty;
    end
  endtask

  task automatic drain(input int budget, input string tag);
    int n;
    n = 0;
    while ((m_fill || t_pend || beat_q.size() != 0 || vram_rd) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) check(tag, 0, 1);
    step();
    step();
  endtask

  task automatic clear_counts();
    n_cb_cmds   = 0;
    n_cb_pulses = 0;
    n_tx_acks   = 0;
  endtask

  task automatic tex_read(input logic [AW-1:0] a, input string tag);
    int d0;
    d0 = t_done;
    n_tx_acks = 0;
    t_pend    = 1;
    t_addr    = a;
    t_cbwait  = 0;
    drain(60, {tag, "_timeout"});
    check({tag, "_acks"}, n_tx_acks, 1);
    check({tag, "_valids"}, t_done - d0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vram_rd"}, vram_rd, 0);
    check({tag, "_vram_addr"}, vram_addr, 0);
    check({tag, "_burstcnt"}, vram_burstcnt, 0);
    check({tag, "_cb_valid"}, cb_valid, 0);
    check({tag, "_cb_data"}, cb_data, 0);
    check({tag, "_tex_ack"}, tex_ack, 0);
    check({tag, "_tex_valid"}, tex_valid, 0);
    check({tag, "_tex_data"}, tex_data, 0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    reset_n = 1'b0;
    cb_wait = 0; cb_offset = '0; cb_base = '0;
    tex_req = 0; tex_addr = '0;
    vram_waitrequest = 0; vram_rdvalid = 0; vram_din = '0;

    // Reset state
    repeat (3) step();
    check_all_zero("reset");
    reset_n = 1'b1;
    step();

    // Codebook fill alone, zero-wait VRAM
    m_base = 23'h100000; m_words = 0; m_fill = 1;
    clear_counts();
    drain(2000, "fill_timeout");
    check("fill_cmds", n_cb_cmds, 256 / BL);
    check("fill_pulses", n_cb_pulses, 256);

    // Texel-only read with a 3-cycle stall
    n_rd_probe = 0;
    force_wait = 3;
    tex_read(23'h0ABC08, "probe");
    check("probe_rd_cycles", n_rd_probe, 4);

    // Stray read-valid while idle
    idle_chk = 1;
    step(); step();
    stray_en = 1;
    step();
    stray_en = 0;
    repeat (3) step();
    idle_chk = 0;
    tex_read(rand_addr(), "post_stray");

    // Both requesters saturated, randomized VRAM timing
    rand_wait = 1; gaps = 1; lat_max = 4;
    m_base = rand_addr(); m_words = 0; m_fill = 1;
    clear_counts();
    alt_en = 1; last_type = 0; t_sat = 1;
    n = 0;
    while (m_fill && n < 6000) begin
      step();
      n++;
    end
    if (n >= 6000) check("sat_timeout", 0, 1);
    t_sat = 0;
    drain(300, "sat_drain_timeout");
    alt_en = 0;
    check("sat_cmds", n_cb_cmds, 256 / BL);
    check("sat_pulses", n_cb_pulses, 256);
    check("sat_tx_reads", (n_tx_acks >= 256 / BL - 1), 1);

    // Cache abandons the fill after 3 words of a burst
    rand_wait = 0; gaps = 0; lat_max = 1;
    m_base = rand_addr(); m_words = 0; drop_at = 3; m_fill = 1;
    clear_counts();
    drain(200, "drop_timeout");
    drop_at = 0;
    idle_chk = 1;
    repeat (6) step();
    idle_chk = 0;
    check("drop_pulses", n_cb_pulses, 3);
    check("drop_cmds", n_cb_cmds, 1);
    tex_read(rand_addr(), "post_drop");

    // Reset during a codebook burst, then restart the fill
    rand_wait = 1; lat_max = 2;
    m_base = rand_addr(); m_words = 0; m_fill = 1;
    n = 0;
    while (m_words < 12 && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) check("midrst_timeout", 0, 1);
    reset_n = 1'b0;
    #1;
    check_all_zero("midrst");
    beat_q.delete();
    m_words = 0; m_fill = 1; last_type = 0; t_pend = 0;
    repeat (3) step();
    reset_n = 1'b1;
    clear_counts();
    drain(2000, "refill_timeout");
    check("refill_cmds", n_cb_cmds, 256 / BL);
    check("refill_pulses", n_cb_pulses, 256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_codebook_vram_sched
`default_nettype wire
